arbitro_enrutamiento_param: RTL and testbench

ARBITRO_ENRUTAMIENTO_PARAM -- requirements
Module: arbitro_enrutamiento_param

---
 rtl/arbitro_enrutamiento_param.sv | 120 ++++++++++++
 tb/tb_arbitro_enrutamiento_param.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/arbitro_enrutamiento_param.sv
// Virtual-channel to destination router: one grant per cycle (strict priority or
// round-robin), registered per-destination write port, forwarded/dropped word counters.
module arbitro_enrutamiento_param #(
    parameter int NUM_VC     = 2,
    parameter int NUM_DEST   = 2,
    parameter int DATA_WIDTH = 6,
    parameter int DEST_LSB   = 4,
    parameter int MODE       = 0
) (
    input  logic                           clk,
    input  logic                           reset_L,
    input  logic [NUM_VC*DATA_WIDTH-1:0]   VC_data,
    input  logic [NUM_VC-1:0]              VC_empty,
    input  logic [NUM_DEST-1:0]            D_pause,
    output logic [NUM_VC-1:0]              VC_pop,
    output logic [NUM_DEST*DATA_WIDTH-1:0] D_out,
    output logic [NUM_DEST-1:0]            D_push,
    output logic [7:0]                     drop_cnt,
    output logic [NUM_DEST*8-1:0]          fwd_cnt
);

    localparam int DB    = $clog2(NUM_DEST);
    localparam int VB    = $clog2(NUM_VC);
    localparam int DSPAN = 1 << DB;
    // One bit per encodable destination code; codes at or above NUM_DEST are drops.
    localparam logic [DSPAN-1:0] VALID_MASK = DSPAN'((64'd1 << NUM_DEST) - 64'd1);

    function automatic logic [DB-1:0] dest_of(input logic [DATA_WIDTH-1:0] word);
        return word[DEST_LSB +: DB];
    endfunction

    function automatic logic [VB-1:0] wrap_idx(input logic [VB-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_VC) s = s - NUM_VC;
        return VB'(s);
    endfunction

    logic [NUM_VC-1:0][DATA_WIDTH-1:0] w_words_p0;
    logic [DSPAN-1:0]                  w_pause_p0;
    logic [NUM_VC-1:0]                 w_elig_p0;
    logic [VB-1:0]                     w_start_p0;
    logic [VB-1:0]                     w_gnt_idx_p0;
    logic                              w_gnt_vld_p0;
    logic [DATA_WIDTH-1:0]             w_gnt_word_p0;
    logic [DB-1:0]                     w_gnt_dest_p0;

    logic [VB-1:0]                          r_last;
    logic [NUM_DEST-1:0]                    r_push_p1;
    logic [NUM_DEST-1:0][DATA_WIDTH-1:0]    r_dout_p1;
    logic [NUM_DEST-1:0][7:0]               r_fwd_p1;
    logic [7:0]                             r_drop_p1;

    // Stage p0: eligibility and grant, all combinational from FIFO heads and pause.
    assign w_words_p0 = VC_data;
    assign w_pause_p0 = DSPAN'(D_pause);

    always_comb begin
        w_elig_p0 = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            w_elig_p0[i] = !VC_empty[i] &&
                           (!VALID_MASK[dest_of(w_words_p0[i])] ||
                            !w_pause_p0[dest_of(w_words_p0[i])]);
        end
    end

    always_comb begin
        w_start_p0 = '0;
        if (MODE == 1) w_start_p0 = wrap_idx(r_last, 1);
    end

    // Scan downward so the candidate closest to the start position wins.
    always_comb begin
        w_gnt_vld_p0 = 1'b0;
        w_gnt_idx_p0 = '0;
        for (int k = NUM_VC - 1; k >= 0; k--) begin
            if (w_elig_p0[wrap_idx(w_start_p0, k)]) begin
                w_gnt_vld_p0 = 1'b1;
                w_gnt_idx_p0 = wrap_idx(w_start_p0, k);
            end
        end
    end

    assign w_gnt_word_p0 = w_words_p0[w_gnt_idx_p0];
    assign w_gnt_dest_p0 = dest_of(w_gnt_word_p0);

    always_comb begin
        VC_pop = '0;
        if (w_gnt_vld_p0 && !reset_L) VC_pop[w_gnt_idx_p0] = 1'b1;
    end

    // Stage p1: destination write port and counters, one cycle after the grant.
    always_ff @(posedge clk or posedge reset_L) begin
        if (reset_L) begin
            r_last    <= VB'(NUM_VC - 1);
            r_push_p1 <= '0;
            r_dout_p1 <= '0;
            r_fwd_p1  <= '0;
            r_drop_p1 <= '0;
        end else begin
            r_push_p1 <= '0;
            if (w_gnt_vld_p0) begin
                r_last <= w_gnt_idx_p0;
                if (VALID_MASK[w_gnt_dest_p0]) begin
                    r_push_p1[w_gnt_dest_p0] <= 1'b1;
                    r_dout_p1[w_gnt_dest_p0] <= w_gnt_word_p0;
                    r_fwd_p1[w_gnt_dest_p0]  <= r_fwd_p1[w_gnt_dest_p0] + 8'd1;
                end else begin
                    r_drop_p1 <= r_drop_p1 + 8'd1;
                end
            end
        end
    end

    assign D_push   = r_push_p1;
    assign D_out    = r_dout_p1;
    assign fwd_cnt  = r_fwd_p1;
    assign drop_cnt = r_drop_p1;

endmodule

// File: tb/tb_arbitro_enrutamiento_param.sv
// Scoreboard bench: three router instances (strict priority, round-robin, three destinations).
module tb_arbitro_enrutamiento_param;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int         dest;
        logic [5:0] word;
    } exp_t;
    exp_t q0[$], q1[$], q2[$];
    exp_t e0, e1, e2;

    // dut0: defaults, strict priority
    logic [11:0] d0_data;  logic [1:0] d0_empty, d0_pause, d0_pop, d0_push;
    logic [11:0] d0_out;   logic [7:0] d0_drop;  logic [15:0] d0_fwd;
    // dut1: round-robin
    logic [11:0] d1_data;  logic [1:0] d1_empty, d1_pause, d1_pop, d1_push;
    logic [11:0] d1_out;   logic [7:0] d1_drop;  logic [15:0] d1_fwd;
    // dut2: three destinations, two-bit destination field
    logic [11:0] d2_data;  logic [1:0] d2_empty, d2_pop;  logic [2:0] d2_pause, d2_push;
    logic [17:0] d2_out;   logic [7:0] d2_drop;  logic [23:0] d2_fwd;

    logic [5:0] bw;

    arbitro_enrutamiento_param #(.NUM_VC(2), .NUM_DEST(2), .DATA_WIDTH(6), .DEST_LSB(4), .MODE(0)) dut0 (
        .clk(clk), .reset_L(rst), .VC_data(d0_data), .VC_empty(d0_empty), .D_pause(d0_pause),
        .VC_pop(d0_pop), .D_out(d0_out), .D_push(d0_push), .drop_cnt(d0_drop), .fwd_cnt(d0_fwd));

    arbitro_enrutamiento_param #(.NUM_VC(2), .NUM_DEST(2), .DATA_WIDTH(6), .DEST_LSB(4), .MODE(1)) dut1 (
        .clk(clk), .reset_L(rst), .VC_data(d1_data), .VC_empty(d1_empty), .D_pause(d1_pause),
        .VC_pop(d1_pop), .D_out(d1_out), .D_push(d1_push), .drop_cnt(d1_drop), .fwd_cnt(d1_fwd));

    arbitro_enrutamiento_param #(.NUM_VC(2), .NUM_DEST(3), .DATA_WIDTH(6), .DEST_LSB(4), .MODE(0)) dut2 (
        .clk(clk), .reset_L(rst), .VC_data(d2_data), .VC_empty(d2_empty), .D_pause(d2_pause),
        .VC_pop(d2_pop), .D_out(d2_out), .D_push(d2_push), .drop_cnt(d2_drop), .fwd_cnt(d2_fwd));

    always @(negedge clk) begin
        if (d0_push !== 2'b00) begin
            if (q0.size() == 0) chk("d0_extra_push", 32'(d0_push), 'h0);
            else begin
                e0 = q0.pop_front();
                chk("d0_push", 32'(d0_push), 32'(1 << e0.dest));
                chk("d0_dout", 32'(d0_out[e0.dest*6 +: 6]), 32'(e0.word));
            end
        end
        if (d1_push !== 2'b00) begin
            if (q1.size() == 0) chk("d1_extra_push", 32'(d1_push), 'h0);
            else begin
                e1 = q1.pop_front();
                chk("d1_push", 32'(d1_push), 32'(1 << e1.dest));
                chk("d1_dout", 32'(d1_out[e1.dest*6 +: 6]), 32'(e1.word));
            end
        end
        if (d2_push !== 3'b000) begin
            if (q2.size() == 0) chk("d2_extra_push", 32'(d2_push), 'h0);
            else begin
                e2 = q2.pop_front();
                chk("d2_push", 32'(d2_push), 32'(1 << e2.dest));
                chk("d2_dout", 32'(d2_out[e2.dest*6 +: 6]), 32'(e2.word));
            end
        end
    end

    task automatic drv0(input logic [5:0] w0, input logic [5:0] w1, input logic [1:0] emp,
                        input logic [1:0] pause, input logic [1:0] exp_pop,
                        input int exp_dest, input logic [5:0] exp_word);
        @(posedge clk); #1;
        d0_data = {w1, w0}; d0_empty = emp; d0_pause = pause;
        #1 chk("d0_pop", 32'(d0_pop), 32'(exp_pop));
        if (exp_dest >= 0) q0.push_back('{exp_dest, exp_word});
    endtask

    task automatic drv1(input logic [5:0] w0, input logic [5:0] w1, input logic [1:0] emp,
                        input logic [1:0] pause, input logic [1:0] exp_pop,
                        input int exp_dest, input logic [5:0] exp_word);
        @(posedge clk); #1;
        d1_data = {w1, w0}; d1_empty = emp; d1_pause = pause;
        #1 chk("d1_pop", 32'(d1_pop), 32'(exp_pop));
        if (exp_dest >= 0) q1.push_back('{exp_dest, exp_word});
    endtask

    task automatic drv2(input logic [5:0] w0, input logic [5:0] w1, input logic [1:0] emp,
                        input logic [2:0] pause, input logic [1:0] exp_pop,
                        input int exp_dest, input logic [5:0] exp_word);
        @(posedge clk); #1;
        d2_data = {w1, w0}; d2_empty = emp; d2_pause = pause;
        #1 chk("d2_pop", 32'(d2_pop), 32'(exp_pop));
        if (exp_dest >= 0) q2.push_back('{exp_dest, exp_word});
    endtask

    initial begin
        d0_data = '0; d0_empty = 2'b11; d0_pause = 2'b00;
        d1_data = '0; d1_empty = 2'b11; d1_pause = 2'b00;
        d2_data = '0; d2_empty = 2'b11; d2_pause = 3'b000;
        bw = 6'h0;
        rst = 1'b0;
        #1 rst = 1'b1;
        d0_data = {6'b000101, 6'b010011}; d0_empty = 2'b00;
        #1;
        chk("rst_pop",   32'(d0_pop),  'h0);
        chk("rst_push",  32'(d0_push), 'h0);
        chk("rst_dout",  32'(d0_out),  'h0);
        chk("rst_fwd",   32'(d0_fwd),  'h0);
        chk("rst_drop",  32'(d0_drop), 'h0);
        chk("rst_drop2", 32'(d2_drop), 'h0);
        d0_empty = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // strict priority: VC0 (dest 1) beats VC1 (dest 0)
        drv0(6'b010011, 6'b000101, 2'b00, 2'b00, 2'b01, 1, 6'b010011);
        drv0(6'b000000, 6'b000101, 2'b01, 2'b00, 2'b10, 0, 6'b000101);
        drv0(6'b000000, 6'b000000, 2'b11, 2'b00, 2'b00, -1, 6'h0);
        chk("d0_hold1", 32'(d0_out[11:6]), 'h13);
        // paused dest 1 blocks VC0 only; release lets it through
        drv0(6'b010111, 6'b001010, 2'b00, 2'b10, 2'b10, 0, 6'b001010);
        drv0(6'b010111, 6'b000000, 2'b10, 2'b10, 2'b00, -1, 6'h0);
        drv0(6'b010111, 6'b000000, 2'b10, 2'b00, 2'b01, 1, 6'b010111);
        drv0(6'b000000, 6'b000000, 2'b11, 2'b00, 2'b00, -1, 6'h0);
        chk("d0_fwd0", 32'(d0_fwd[7:0]),  2);
        chk("d0_fwd1", 32'(d0_fwd[15:8]), 2);
        chk("d0_drop", 32'(d0_drop), 0);
        chk("d0_hold0", 32'(d0_out[5:0]), 'h0A);

        // round-robin alternation, then bulk forwards to wrap fwd_cnt[0]
        drv1(6'h20, 6'h01, 2'b00, 2'b00, 2'b01, 0, 6'h20);
        drv1(6'h21, 6'h01, 2'b00, 2'b00, 2'b10, 0, 6'h01);
        drv1(6'h21, 6'h02, 2'b00, 2'b00, 2'b01, 0, 6'h21);
        drv1(6'h22, 6'h02, 2'b00, 2'b00, 2'b10, 0, 6'h02);
        drv1(6'h00, 6'h00, 2'b11, 2'b00, 2'b00, -1, 6'h0);
        chk("d1_fwd0_4", 32'(d1_fwd[7:0]),  4);
        chk("d1_fwd1_0", 32'(d1_fwd[15:8]), 0);
        drv1(6'h00, 6'h03, 2'b01, 2'b00, 2'b10, 0, 6'h03);
        for (int k = 0; k < 250; k++) begin
            bw = 6'(k) & 6'h2F;
            drv1(bw, 6'h00, 2'b10, 2'b00, 2'b01, 0, bw);
        end
        drv1(6'h00, 6'h00, 2'b11, 2'b00, 2'b00, -1, 6'h0);
        chk("d1_fwd0_255", 32'(d1_fwd[7:0]), 255);
        drv1(6'h0A, 6'h00, 2'b10, 2'b00, 2'b01, 0, 6'h0A);
        drv1(6'h00, 6'h00, 2'b11, 2'b00, 2'b00, -1, 6'h0);
        chk("d1_fwd0_wrap", 32'(d1_fwd[7:0]), 0);

        // invalid destination 3 is dropped even with every destination paused
        drv2(6'b110001, 6'b100111, 2'b00, 3'b111, 2'b01, -1, 6'h0);
        drv2(6'b000000, 6'b100111, 2'b01, 3'b000, 2'b10, 2, 6'b100111);
        chk("d2_drop1",  32'(d2_drop), 1);
        chk("d2_nopush", 32'(d2_push), 0);
        drv2(6'b000000, 6'b000000, 2'b11, 3'b000, 2'b00, -1, 6'h0);
        chk("d2_fwd2", 32'(d2_fwd[23:16]), 1);

        // reset asserted mid-cycle while a push is on the output
        drv0(6'b010011, 6'b000000, 2'b10, 2'b00, 2'b01, -1, 6'h0);
        @(posedge clk); #1;
        d0_empty = 2'b11;
        chk("d0_pend_push", 32'(d0_push), 'h2);
        chk("d0_pend_fwd1", 32'(d0_fwd[15:8]), 3);
        #2 rst = 1'b1;
        d0_data = {6'h05, 6'h13}; d0_empty = 2'b00;
        #1;
        chk("r_pop",   32'(d0_pop),  'h0);
        chk("r_push",  32'(d0_push), 'h0);
        chk("r_dout",  32'(d0_out),  'h0);
        chk("r_fwd0",  32'(d0_fwd),  'h0);
        chk("r_fwd1",  32'(d1_fwd),  'h0);
        chk("r_fwd2",  32'(d2_fwd),  'h0);
        chk("r_drop2", 32'(d2_drop), 'h0);
        d0_empty = 2'b11;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1 chk("r_nopush_a", 32'(d0_push), 'h0);
        @(posedge clk); #1 chk("r_nopush_b", 32'(d0_push), 'h0);
        drv0(6'h13, 6'h00, 2'b10, 2'b00, 2'b01, 1, 6'h13);
        drv0(6'h00, 6'h00, 2'b11, 2'b00, 2'b00, -1, 6'h0);
        drv1(6'h20, 6'h01, 2'b00, 2'b00, 2'b01, 0, 6'h20);
        drv1(6'h00, 6'h00, 2'b11, 2'b00, 2'b00, -1, 6'h0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("q0_left", 32'(q0.size()), 0);
        chk("q1_left", 32'(q1.size()), 0);
        chk("q2_left", 32'(q2.size()), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
